// File: rtl/mmap_read_stream.sv
// mmap_read_stream
//   Read-side front-end for the asynchronous memory-mapped port. Takes one
//   (base, word count) request at a time, pushes sequential word addresses
//   into the read-address FIFO and forwards returned words from the
//   read-data FIFO onto a valid/ready stream with a last flag. The number
//   of issued-but-unpopped words is capped at MaxOutstanding so the
//   read-data buffer can never overflow.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_base/len/valid  request (byte base, word count); req_ready accepts
//   read_addr_*         push side of the read-address FIFO
//   read_data_*         pop side of the read-data FIFO
//   out_data/last/valid stream output, out_ready backpressure
//   busy                request in progress
//
// Optional build macro MMAP_READ_STREAM_STATS_EN adds stat_words and
// stat_stall saturating counters.
module mmap_read_stream #(
  parameter int unsigned AddrWidth         = 64,
  parameter int unsigned DataWidth         = 512,
  parameter int unsigned DataWidthBytesLog = 6,
  parameter int unsigned LenWidth          = 32,
  parameter int unsigned MaxOutstanding    = 64,
  parameter int unsigned OutstandingLog    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AddrWidth-1:0] req_base,
  input  logic [LenWidth-1:0]  req_len,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [AddrWidth-1:0] read_addr_din,
  output logic                 read_addr_write,
  input  logic                 read_addr_full_n,
  input  logic [DataWidth-1:0] read_data_dout,
  output logic                 read_data_read,
  input  logic                 read_data_empty_n,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
`ifdef MMAP_READ_STREAM_STATS_EN
  ,
  output logic [31:0]          stat_words,
  output logic [31:0]          stat_stall
`endif
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t                    r_state;
  logic [AddrWidth-1:0]      r_base;
  logic [LenWidth-1:0]       r_len;
  logic [LenWidth-1:0]       r_issued;
  logic [LenWidth-1:0]       r_received;
  logic [OutstandingLog-1:0] r_outstanding;

  logic w_run;
  logic w_issue;
  logic w_pop;
  logic w_accept;
  logic w_final;

  assign w_run   = (r_state == S_RUN);
  // Issue depends only on registered state and the address FIFO, never on
  // out_ready, so there is no combinational path from the stream sink.
  assign w_issue = w_run && (r_issued < r_len)
                 && (r_outstanding < OutstandingLog'(MaxOutstanding))
                 && read_addr_full_n;
  assign w_final = (r_received == (r_len - LenWidth'(1)));

  // IDLE is the reset state, so req_ready is gated to stay low during reset.
  assign req_ready       = !rst && (r_state == S_IDLE);
  assign w_accept        = req_valid && req_ready;
  assign busy            = w_run;
  assign out_valid       = w_run && read_data_empty_n;
  assign w_pop           = out_valid && out_ready;
  assign read_data_read  = w_pop;
  assign out_data        = read_data_dout;
  assign out_last        = out_valid && w_final;
  assign read_addr_write = w_issue;
  assign read_addr_din   = r_base + (AddrWidth'(r_issued) << DataWidthBytesLog);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Zero-length requests are accepted and silently dropped.
          if (w_accept && (req_len != '0)) begin
            r_base     <= req_base;
            r_len      <= req_len;
            r_issued   <= '0;
            r_received <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue) r_issued <= r_issued + LenWidth'(1);
          if (w_pop) begin
            r_received <= r_received + LenWidth'(1);
            if (w_final) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Simultaneous issue and pop leave the credit count unchanged.
      case ({w_issue, w_pop})
        2'b10:   r_outstanding <= r_outstanding + OutstandingLog'(1);
        2'b01:   r_outstanding <= r_outstanding - OutstandingLog'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

`ifdef MMAP_READ_STREAM_STATS_EN
  logic [31:0] r_stat_words;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_words <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_pop && (r_stat_words != '1)) r_stat_words <= r_stat_words + 32'd1;
      if (w_run && read_data_empty_n && !out_ready && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_words = r_stat_words;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_mmap_read_stream.sv
// Testbench for mmap_read_stream. External FIFOs and the memory behind them
// are modelled with queues; expected addresses, data and last flags are
// derived from the request (base + i*64, word i, i == len-1).
module tb_mmap_read_stream;

  localparam int AW   = 64;
  localparam int DW   = 512;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] req_base;
  logic [31:0]   req_len;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] read_addr_din;
  logic          read_addr_write;
  logic          read_addr_full_n;
  logic [DW-1:0] read_data_dout;
  logic          read_data_read;
  logic          read_data_empty_n;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef MMAP_READ_STREAM_STATS_EN
  logic [31:0]   stat_words;
  logic [31:0]   stat_stall;
`endif

  mmap_read_stream #(
    .AddrWidth(AW),
    .DataWidth(DW),
    .DataWidthBytesLog(6),
    .LenWidth(32),
    .MaxOutstanding(MAXO),
    .OutstandingLog(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_base(req_base),
    .req_len(req_len),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .read_addr_din(read_addr_din),
    .read_addr_write(read_addr_write),
    .read_addr_full_n(read_addr_full_n),
    .read_data_dout(read_data_dout),
    .read_data_read(read_data_read),
    .read_data_empty_n(read_data_empty_n),
    .out_data(out_data),
    .out_last(out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
`ifdef MMAP_READ_STREAM_STATS_EN
    ,
    .stat_words(stat_words),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Environment state
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  int rdy_mode;      // 0 low, 1 high, 2 toggle, 3 random, 4 stall budget
  int full_mode;     // 1 never full, otherwise random
  int mem_credits;   // <0 unlimited, else number of words memory may return
  int stall_left;

  // Reference transaction
  logic [AW-1:0] cur_base;
  int cur_len;
  int wr_idx;
  int rd_idx;
  bit active;
  int pops_since_rst;
  int stall_since_rst;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a, a ^ 64'h5555_aaaa_3c3c_c3c3, a + 64'd1,
            {4{a ^ 64'h0123_4567_89ab_cdef}}};
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int idx);
    return cur_base + 64'(idx) * 64'd64;
  endfunction

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    read_addr_full_n  = (full_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    read_data_empty_n = (data_q.size() != 0);
    read_data_dout    = (data_q.size() != 0) ? data_q[0] : {16{$urandom}};
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ~out_ready;
      3:       out_ready = ($urandom_range(0, 1) == 1);
      default: begin
        if (read_data_empty_n && (stall_left > 0)) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  endtask

  // One clock cycle: observe at negedge, advance the model after posedge.
  task automatic step();
    bit            ev_wr;
    bit            ev_rd;
    logic [AW-1:0] wa;
    @(negedge clk);
    ev_wr = read_addr_write;
    ev_rd = read_data_read;
    wa    = read_addr_din;
    if (!active)
      chkb("idle_quiet", read_addr_write | read_data_read | out_valid, 1'b0);
    if (read_addr_write) begin
      chkb("wr_legal", active && (wr_idx < cur_len) && read_addr_full_n, 1'b1);
      chkw("addr", DW'(read_addr_din), DW'(exp_addr(wr_idx)));
    end
    if (out_valid) chkb("last", out_last, rd_idx == cur_len - 1);
    if (read_data_read) begin
      chkb("pop_legal", active && out_ready && (data_q.size() != 0), 1'b1);
      chkw("data", out_data, mem_word(exp_addr(rd_idx)));
    end else if (out_valid) begin
      chkb("hold_not_ready", out_ready, 1'b0);
    end
    chkb("busy", busy, active);
    chkb("req_ready", req_ready, !active);
    if (active && read_data_empty_n && !out_ready) stall_since_rst++;
    @(posedge clk);
    #1;
    if (ev_wr) begin
      addr_q.push_back(wa);
      wr_idx++;
      chkb("inflight_cap", (wr_idx - rd_idx) <= MAXO, 1'b1);
    end
    if (ev_rd) begin
      void'(data_q.pop_front());
      rd_idx++;
      pops_since_rst++;
      if (rd_idx == cur_len) active = 1'b0;
    end
    if ((addr_q.size() != 0) && (mem_credits != 0)) begin
      data_q.push_back(mem_word(addr_q.pop_front()));
      if (mem_credits > 0) mem_credits--;
    end
    chkb("data_fifo_no_overflow", data_q.size() <= MAXO, 1'b1);
    apply_inputs();
  endtask

  task automatic start_req(input logic [AW-1:0] base, input int len);
    req_base  = base;
    req_len   = 32'(len);
    req_valid = 1'b1;
    @(negedge clk);
    chkb("accept_ready", req_ready, 1'b1);
    chkb("accept_no_wr", read_addr_write, 1'b0);
    chkb("accept_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_base  = {$urandom, $urandom};
    req_len   = $urandom;
    cur_base  = base;
    cur_len   = len;
    wr_idx    = 0;
    rd_idx    = 0;
    active    = (len != 0);
    apply_inputs();
  endtask

  task automatic finish_req(input int budget);
    for (int c = 0; c < budget && active; c++) step();
    chkb("complete_in_time", active, 1'b0);
    chki("words_popped", rd_idx, cur_len);
    step();  // req_ready must be back one cycle after the final pop
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    addr_q.delete();
    data_q.delete();
    active          = 1'b0;
    wr_idx          = 0;
    rd_idx          = 0;
    cur_len         = 0;
    pops_since_rst  = 0;
    stall_since_rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    apply_inputs();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_base = '0; req_len = '0;
    read_addr_full_n = 1'b1; read_data_empty_n = 1'b1; read_data_dout = '0;
    out_ready = 1'b1;
    rdy_mode = 1; full_mode = 1; mem_credits = -1; stall_left = 0;
    cur_base = '0; cur_len = 0; wr_idx = 0; rd_idx = 0; active = 1'b0;
    pops_since_rst = 0; stall_since_rst = 0;

    // Reset state, with stray data presented
    @(negedge clk);
    chkb("rst_req_ready", req_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_read", read_data_read, 1'b0);
    do_reset();

    // Basic: back-to-back addresses from 0x1000
    start_req(64'h1000, 4);
    repeat (4) step();
    chki("basic_consecutive_issue", wr_idx, 4);
    finish_req(50);

    // Credit cap: memory withholds data
    mem_credits = 0;
    start_req(64'h8000, 10);
    repeat (12) step();
    chki("cap_writes", wr_idx, MAXO);
    mem_credits = 1;
    repeat (6) step();
    chki("cap_release_writes", wr_idx, MAXO + 1);
    chki("cap_release_pops", rd_idx, 1);
    mem_credits = -1;
    finish_req(100);

    // Backpressure: out_ready toggles
    rdy_mode = 2;
    start_req(64'h20_0000, 3);
    finish_req(60);

    // Randomized transactions
    rdy_mode = 3; full_mode = 2;
    for (int t = 0; t < 6; t++) begin
      start_req({$urandom, $urandom} & ~64'h3f, $urandom_range(1, 12));
      finish_req(400);
    end
    rdy_mode = 1; full_mode = 1;

    // Zero length with stray data present: nothing happens
    data_q.push_back({16{32'hdead_beef}});
    apply_inputs();
    start_req(64'h5000, 0);
    repeat (4) step();
    chki("zero_len_writes", wr_idx, 0);
    data_q.delete();
    apply_inputs();

    // Address wrap
    start_req(64'hFFFF_FFFF_FFFF_FFC0, 2);
    finish_req(40);

`ifdef MMAP_READ_STREAM_STATS_EN
    chki("stat_words_running", int'(stat_words), pops_since_rst);
    chki("stat_stall_running", int'(stat_stall), stall_since_rst);
`endif

    // Reset mid-run
    mem_credits = 0;
    start_req(64'h2000, 8);
    for (int c = 0; c < 20 && wr_idx < 2; c++) step();
    chki("midrun_writes", wr_idx, 2);
    #2;
    read_data_empty_n = 1'b1;
    out_ready         = 1'b1;
    read_addr_full_n  = 1'b1;
    rst               = 1'b1;
    #1;
    chkb("arst_req_ready", req_ready, 1'b0);
    chkb("arst_addr_write", read_addr_write, 1'b0);
    chkb("arst_data_read", read_data_read, 1'b0);
    chkb("arst_out_valid", out_valid, 1'b0);
    chkb("arst_out_last", out_last, 1'b0);
    chkb("arst_busy", busy, 1'b0);
    mem_credits = -1;
    do_reset();
    step();
    start_req(64'h3000, 1);
    finish_req(40);

`ifdef MMAP_READ_STREAM_STATS_EN
    // Exactly three stall cycles on a four-word request
    do_reset();
    rdy_mode   = 4;
    stall_left = 3;
    start_req(64'h4000, 4);
    finish_req(60);
    chki("stat_words", int'(stat_words), 4);
    chki("stat_stall", int'(stat_stall), 3);
    rdy_mode = 1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
